// File: rtl/ddr3_burst_seq.sv
// DDR3 burst sequencer: turns one READ/WRITE burst command into per-beat JEDEC column addresses on a dual-port RAM.
// Latency: read addresses t+1..t+N, read data t+2..t+N+1; each write beat reaches the RAM one cycle after it is accepted.
// Backpressure: cmd_ready only in IDLE; wr_ready only in WRITE, where wr_valid=0 stalls the burst; reads never stall.
module ddr3_burst_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 36
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_bank,
  input  logic [15:0]           cmd_row,
  input  logic [15:0]           cmd_col,
  input  logic                  cmd_bc4,
  input  logic                  cmd_interleave,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [2:0]  beat;
  logic [2:0]  bank_q;
  logic [15:0] row_q;
  logic [15:0] col_q;
  logic        bc4_q;
  logic        interleave_q;
  logic        last_beat;

  // Column for beat i: bits [15:3] are held, bits [2:0] wrap inside the burst and never carry upward.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(
    input logic [2:0]  b,
    input logic [15:0] r,
    input logic [15:0] c,
    input logic        bc4,
    input logic        il,
    input logic [2:0]  i
  );
    logic [2:0] s;
    logic [2:0] cl;
    s = c[2:0];
    if (il) begin
      cl = s ^ i;
    end else begin
      cl[1:0] = s[1:0] + i[1:0];
      cl[2]   = s[2] ^ i[2];
    end
    // A chopped burst stays in the start half of the 8-column block.
    if (bc4) cl[2] = s[2];
    return ADDR_WIDTH'({1'b0, b, r, c[15:3], cl});
  endfunction

  // Handshake readiness is a pure decode of the current state.
  assign cmd_ready = (state == ST_IDLE);
  assign wr_ready  = (state == ST_WRITE);
  assign rd_data   = ram_do;
  assign last_beat = (beat == (bc4_q ? 3'd3 : 3'd7));

  // Burst FSM plus the registered RAM-side address/data/strobe outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      beat           <= '0;
      bank_q         <= '0;
      row_q          <= '0;
      col_q          <= '0;
      bc4_q          <= 1'b0;
      interleave_q   <= 1'b0;
      ram_we         <= 1'b0;
      ram_write_addr <= '0;
      ram_di         <= '0;
      ram_read_addr  <= '0;
      rd_valid       <= 1'b0;
      rd_last        <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            bank_q       <= cmd_bank;
            row_q        <= cmd_row;
            col_q        <= cmd_col;
            bc4_q        <= cmd_bc4;
            interleave_q <= cmd_interleave;
            beat         <= '0;
            if (cmd_write) begin
              state <= ST_WRITE;
            end else begin
              // First read address goes out the cycle right after acceptance.
              state         <= ST_READ;
              ram_read_addr <= beat_addr(cmd_bank, cmd_row, cmd_col, cmd_bc4, cmd_interleave, 3'd0);
            end
          end
        end
        ST_WRITE: begin
          if (wr_valid) begin
            ram_we         <= 1'b1;
            ram_write_addr <= beat_addr(bank_q, row_q, col_q, bc4_q, interleave_q, beat);
            ram_di         <= wr_data;
            if (last_beat) state <= ST_IDLE;
            else           beat  <= beat + 3'd1;
          end
        end
        ST_READ: begin
          // RAM data for the address shown this cycle arrives next cycle.
          rd_valid <= 1'b1;
          rd_last  <= last_beat;
          if (last_beat) begin
            state <= ST_DRAIN;
          end else begin
            beat          <= beat + 3'd1;
            ram_read_addr <= beat_addr(bank_q, row_q, col_q, bc4_q, interleave_q, beat + 3'd1);
          end
        end
        default: begin
          // DRAIN: last read beat is on rd_data this cycle.
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ddr3_burst_seq.md
Name: ddr3_burst_seq

Overview:
- Command-side front end for the BFM storage array.
- Accepts one DDR3 READ or WRITE burst command (bank/row/col, BL8 or BC4, sequential or interleaved ordering).
- Generates the per-beat JEDEC column sequence and drives the single-clock dual-port RAM's write port (we/write_addr/di) or read port (read_addr/do).
- Returns read beats with valid/last framing; one burst in flight at a time.

Parameters:
- DATA_WIDTH, 8, width of one beat and of the RAM data ports.
- ADDR_WIDTH, 36, width of the RAM address ports; packed as {1'b0, bank[2:0], row[15:0], col[15:0]}.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1=WRITE, 0=READ.
- cmd_bank  in  3  bank address.
- cmd_row  in  16  row address.
- cmd_col  in  16  start column; [2:0] is the burst start offset.
- cmd_bc4  in  1  1=burst chop 4 beats, 0=BL8.
- cmd_interleave  in  1  1=interleaved order, 0=sequential.
- wr_data  in  DATA_WIDTH  write beat data.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  write beat accepted when wr_valid & wr_ready.
- rd_data  out  DATA_WIDTH  read beat data.
- rd_valid  out  1  rd_data valid this cycle.
- rd_last  out  1  final beat of a read burst.
- ram_we  out  1  RAM write enable.
- ram_write_addr  out  ADDR_WIDTH  RAM write address.
- ram_di  out  DATA_WIDTH  RAM write data.
- ram_read_addr  out  ADDR_WIDTH  RAM read address.
- ram_do  in  DATA_WIDTH  RAM read data; one cycle after read_addr, updated only while we=0.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE.
  - cmd_ready=1; wr_ready=0; rd_valid=0; rd_last=0; ram_we=0.
  - ram_write_addr=0; ram_read_addr=0; ram_di=0; beat counter=0.
- Reset mid-burst: burst abandoned. Beats already written stay in RAM. No further rd_valid.
- States:
  - IDLE: cmd_ready=1. On accept, latch bank/row/col/bc4/interleave, clear beat counter, go to WRITE or READ.
  - WRITE: wr_ready=1. Each accepted beat is registered and appears next cycle as ram_we=1, ram_write_addr=beat address, ram_di=wr_data. With wr_valid=0 the block stalls and ram_we=0. After the last beat is accepted, go to IDLE.
  - READ: each cycle presents ram_read_addr=beat address (registered), ram_we=0. After the last address, go to DRAIN.
  - DRAIN: one cycle, then IDLE.
- N = 4 if bc4 else 8. Beat index i = 0..N-1. s = cmd_col[2:0].
- Beat column:
  - col[15:3] is held from the command.
  - Sequential: col[1:0]=(s[1:0]+i) mod 4; col[2]=s[2] XOR (i>=4).
  - Interleaved: col[2:0] = s XOR i.
  - BC4: col[2]=s[2] for all beats.
  - Column never carries out of bit 2 (wrap within the burst).
- Read latency, command accepted at cycle t:
  - ram_read_addr beats at t+1..t+N.
  - rd_valid=1 at t+2..t+N+1, with rd_data=ram_do (combinational pass-through).
  - rd_last=1 at t+N+1 only.
  - cmd_ready=1 again at t+N+2.
- Write timing: last beat accepted at cycle k gives cmd_ready=1 at k+1. That final beat's ram_we is still 1 at k+1.
  - A READ accepted at k+1 presents its address at k+2.
  - Read-after-write to the same column therefore returns the new data.
- ram_we is never 1 while a read address is being presented.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- wr_valid outside WRITE is ignored.
- rd_valid and ram_we are never both 1 in the same cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles during an active BL8 read -> next cycle cmd_ready=1, rd_valid=0, ram_we=0, all addresses 0.
- WRITE BL8 sequential, bank=2, row=0x0005, col=0x0011, wr_data 0xA0..0xA7 back-to-back -> ram_write_addr col bits cycle 1,2,3,0,5,6,7,4 (col=0x0011,0x0012,0x0013,0x0010,0x0015,...); address = {1'b0,3'd2,16'h0005,col}.
- READ the same location, col=0x0011, BL8 sequential -> rd_data A0..A7 on 8 consecutive cycles starting 2 cycles after accept; rd_last with A7; cmd_ready low for 9 cycles.
- READ interleaved, col=0x0005 -> read col[2:0] order 5,4,7,6,1,0,3,2.
- BC4 write, sequential, col=0x0006, with wr_valid deasserted for 2 cycles after beat 1 -> col[2:0] 6,7,4,5; ram_we gaps match the stalls; exactly 4 writes.
- READ accepted the cycle after the final write beat, same address -> rd_data equals the freshly written byte.
